// File: rtl/hdec_pkg.sv
// hdec_pkg: shared types and helpers for the thermometer half-encoder/decoder.
//   MAX_N / MAX_W  : largest supported binary width (6) and code width (64).
//   code_w(n)      : code width 2**n for a binary width n.
//   henc_payload_t : per-stage payload {code, prefix, err} sized for MAX_N;
//                    narrower instances use the low bits and keep the rest 0.
//   therm_legal()  : 1 when the low 2**n bits of code form a legal
//                    thermometer code (contiguous low ones, top bit 0).
package hdec_pkg;

  localparam int unsigned MAX_N = 6;
  localparam int unsigned MAX_W = 64;

  function automatic int unsigned code_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

  typedef struct packed {
    logic [MAX_W-1:0] code;
    logic [MAX_N-1:0] prefix;
    logic             err;
  } henc_payload_t;

  // Bit-parallel form: no 1 may sit above a 0, and the top code bit must be 0.
  // Both reduce to masked tests on (code >> 1) and on the top bit.
  function automatic logic therm_legal(input logic [MAX_W-1:0] code,
                                       input int unsigned      n);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] c;
    logic             top_ok;
    logic             step_ok;
    mask    = (n >= MAX_N) ? '1 : ((64'd1 << code_w(n)) - 64'd1);
    c       = code & mask;
    top_ok  = ((c & ~(mask >> 1)) == '0);
    step_ok = (((c >> 1) & ~c) == '0);
    return top_ok & step_ok;
  endfunction

endpackage

// File: rtl/henc_stage.sv
// henc_stage: one registered binary-search stage of henc_pipe.
//   Stage K resolves result bit N-1-K by sampling code[T-1], where T is the
//   prefix decided so far with bit N-1-K set.
//   clk, rst_n         : clock, async active-low reset
//   stall              : global hold; all registers keep their value
//   in_valid / in_pl   : item from the previous stage (or pipe entry)
//   out_valid / out_pl : registered item for the next stage
module henc_stage
  import hdec_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          in_valid,
  input  henc_payload_t in_pl,
  output logic          out_valid,
  output henc_payload_t out_pl
);

  localparam int unsigned B = N - 1 - K;

  logic [MAX_N-1:0] t;
  logic [MAX_N-1:0] idx;
  henc_payload_t    nxt;

  // Lower prefix bits are still zero here, so setting bit B yields T directly.
  always_comb begin
    t              = in_pl.prefix;
    t[B]           = 1'b1;
    idx            = t - MAX_N'(1);
    nxt            = in_pl;
    nxt.prefix[B]  = in_pl.code[idx];
  end

  // Data loads only with a real item so bubbles leave the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pl    <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_pl <= nxt;
      end
    end
  end

endmodule

// File: rtl/henc_pipe.sv
// henc_pipe: pipelined half-encoder, 2**N-bit thermometer code -> N-bit value.
//   Build option: define HENC_CHECK_EN to build the legality check; when
//   undefined out_err is tied low and latency/handshake are unchanged.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : input handshake; in_ready = ~stall
//   in_code             : thermometer code (code[i]=1 iff i < value)
//   out_valid/out_ready : output handshake; stall = out_valid & ~out_ready
//   out_bin             : encoded value, N cycles after acceptance
//   out_err             : in_code was not a legal thermometer code
module henc_pipe
  import hdec_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2**N-1:0] in_code,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_bin,
  output logic           out_err
);

  localparam int unsigned CW = 2**N;

  logic          stall;
  henc_payload_t head;
  henc_payload_t pl  [N+1];
  logic          vld [N+1];

  assign stall    = vld[N] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    head               = '0;
    head.code[CW-1:0]  = in_code;
`ifdef HENC_CHECK_EN
    head.err           = ~therm_legal(head.code, N);
`else
    head.err           = 1'b0;
`endif
  end

  assign pl[0]  = head;
  assign vld[0] = in_valid;

  for (genvar k = 0; k < N; k++) begin : g_stage
    henc_stage #(.N(N), .K(k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall    (stall),
      .in_valid (vld[k]),
      .in_pl    (pl[k]),
      .out_valid(vld[k+1]),
      .out_pl   (pl[k+1])
    );
  end

  assign out_valid = vld[N];
  assign out_bin   = pl[N].prefix[N-1:0];
  assign out_err   = pl[N].err;

endmodule
